// File: rtl/dmem_lsu.sv
// Load/store sequencer driving the byte-masked rv32is dmem port with single-cycle read/write strobes.
// Define DMEM_LSU_MISALIGN_EN to split misaligned accesses into byte accesses; otherwise they respond with an error.
module dmem_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    input  logic        req_we,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic [2:0]  mem_memop,
    output logic        mem_we,
    output logic        mem_rdstb,
    output logic        mem_wrstb,
    input  logic [31:0] mem_dataout
);
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 3;

`ifdef DMEM_LSU_MISALIGN_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RD = 3'd1, S_CAP = 3'd2, S_SRD = 3'd3,
        S_SWR = 3'd4, S_NEXT = 3'd5, S_RESP = 3'd6
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RD = 3'd1, S_CAP = 3'd2, S_SRD = 3'd3,
        S_SWR = 3'd4, S_RESP = 3'd6
    } state_e;
`endif

    state_e         state_q;
    logic           ready_q;
    logic           busy_q;
    logic           resp_valid_q;
    logic           resp_err_q;
    logic [DW-1:0]  resp_rdata_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_datain_q;
    logic [OPW-1:0] mem_memop_q;
    logic           mem_we_q;
    logic           mem_rdstb_q;
    logic           mem_wrstb_q;

    logic accept;
    logic req_bad;
    logic req_misal;

    assign accept    = req_valid & ready_q;
    // Illegal encodings (011, 11x) and stores with the unsigned bit set.
    assign req_bad   = (req_memop == 3'b011) | (req_memop[2:1] == 2'b11) | (req_we & req_memop[2]);
    assign req_misal = ((req_memop[1:0] == 2'b10) & (req_addr[1:0] != 2'b00)) |
                       ((req_memop[1:0] == 2'b01) & req_addr[0]);

`ifdef DMEM_LSU_MISALIGN_EN
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] ext_d;
    logic          we_q;
    logic          sext_q;
    logic          split_q;
    logic [1:0]    cnt_q;
    logic [1:0]    last_q;
    logic [1:0]    cnt_inc;

    assign cnt_inc = cnt_q + 2'd1;

    // Byte insertion for split loads; only lh needs sign extension after assembly.
    always_comb begin
        acc_d = acc_q;
        acc_d[{cnt_q, 3'b000} +: 8] = mem_dataout[7:0];
        ext_d = sext_q ? {{16{acc_d[15]}}, acc_d[15:0]} : acc_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
            mem_memop_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_rdstb_q  <= 1'b0;
            mem_wrstb_q  <= 1'b0;
`ifdef DMEM_LSU_MISALIGN_EN
            addr_q       <= '0;
            wdata_q      <= '0;
            acc_q        <= '0;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            split_q      <= 1'b0;
            cnt_q        <= '0;
            last_q       <= '0;
`endif
        end else begin
            // Strobes are single-cycle and the dmem bus idles at zero unless a state holds it.
            resp_valid_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
            mem_memop_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_rdstb_q  <= 1'b0;
            mem_wrstb_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef DMEM_LSU_MISALIGN_EN
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        sext_q  <= (req_memop == 3'b001);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        last_q  <= req_memop[1] ? 2'd3 : 2'd1;
                        split_q <= 1'b0;
`endif
                        if (req_bad) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state_q      <= S_RESP;
                        end else if (req_misal) begin
`ifdef DMEM_LSU_MISALIGN_EN
                            split_q      <= 1'b1;
                            mem_addr_q   <= req_addr;
                            mem_datain_q <= {24'h0, req_wdata[7:0]};
                            mem_memop_q  <= req_we ? 3'b000 : 3'b100;
                            mem_we_q     <= req_we;
                            mem_rdstb_q  <= 1'b1;
                            state_q      <= req_we ? S_SRD : S_RD;
`else
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state_q      <= S_RESP;
`endif
                        end else begin
                            mem_addr_q   <= req_addr;
                            mem_datain_q <= req_wdata;
                            mem_memop_q  <= req_memop;
                            mem_we_q     <= req_we;
                            mem_rdstb_q  <= 1'b1;
                            state_q      <= req_we ? S_SRD : S_RD;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
`ifdef DMEM_LSU_MISALIGN_EN
                    if (split_q) begin
                        acc_q <= acc_d;
                        if (cnt_q == last_q) begin
                            resp_rdata_q <= ext_d;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end else begin
                        resp_rdata_q <= mem_dataout;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
`else
                    resp_rdata_q <= mem_dataout;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
`endif
                end
                S_SRD: begin
                    // Write half of the read-modify-write: hold the bus and fire the write strobe.
                    mem_addr_q   <= mem_addr_q;
                    mem_datain_q <= mem_datain_q;
                    mem_memop_q  <= mem_memop_q;
                    mem_we_q     <= 1'b1;
                    mem_wrstb_q  <= 1'b1;
                    state_q      <= S_SWR;
                end
                S_SWR: begin
`ifdef DMEM_LSU_MISALIGN_EN
                    if (split_q && (cnt_q != last_q)) begin
                        state_q <= S_NEXT;
                    end else begin
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
`else
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
`endif
                end
`ifdef DMEM_LSU_MISALIGN_EN
                S_NEXT: begin
                    cnt_q        <= cnt_inc;
                    mem_addr_q   <= addr_q + AW'(cnt_inc);
                    mem_datain_q <= {24'h0, wdata_q[{cnt_inc, 3'b000} +: 8]};
                    mem_memop_q  <= we_q ? 3'b000 : 3'b100;
                    mem_we_q     <= we_q;
                    mem_rdstb_q  <= 1'b1;
                    state_q      <= we_q ? S_SRD : S_RD;
                end
`endif
                S_RESP: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_datain = mem_datain_q;
    assign mem_memop  = mem_memop_q;
    assign mem_we     = mem_we_q;
    assign mem_rdstb  = mem_rdstb_q;
    assign mem_wrstb  = mem_wrstb_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a small byte-masked dmem model; honours DMEM_LSU_MISALIGN_EN.
module tb_dmem_lsu;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_memop;
    logic        req_we;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic [2:0]  mem_memop;
    logic        mem_we;
    logic        mem_rdstb;
    logic        mem_wrstb;
    logic [31:0] mem_dataout;

`ifdef DMEM_LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [31:0] rd_addrs[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          e0_cyc = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_resp = 0;
    logic        cur_we = 1'b0;
    string       cur_name = "reset";

    dmem_lsu dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_memop(req_memop), .req_we(req_we),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_memop(mem_memop), .mem_we(mem_we),
        .mem_rdstb(mem_rdstb), .mem_wrstb(mem_wrstb), .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", cur_name, name, act, exp);
        end
    endtask

    // dmem model: read extends per memop, write merges per memop
    function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] wr_merge(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (op[1:0])
            2'b00:   r[{a, 3'b000} +: 8] = d[7:0];
            2'b01:   if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]      <= 32'h80FF7F01;
            mem[4]      <= 32'hDEADBEEF;
            mem[8]      <= 32'h44332211;
            mem[9]      <= 32'h88776655;
            mem[10]     <= 32'h000000CC;
            mem_dataout <= 32'h0;
        end else begin
            if (mem_rdstb) mem_dataout <= rd_ext(mem[mem_addr[7:2]], mem_addr[1:0], mem_memop);
            if (mem_wrstb) mem[mem_addr[7:2]] <= wr_merge(mem[mem_addr[7:2]], mem_addr[1:0], mem_memop, mem_datain);
        end
    end

    // Monitor: strobe bookkeeping, idle bus check and scoreboard pop on resp_valid.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rdstb) begin
                n_rd++;
                rd_addrs.push_back(mem_addr);
                chk("rd_we", 32'(mem_we), 32'(cur_we));
            end
            if (mem_wrstb) begin
                n_wr++;
                chk("wr_we", 32'(mem_we), 32'd1);
            end
            if (req_ready)
                chk("idle_mem", 32'(|{mem_addr, mem_datain, mem_memop, mem_we, mem_rdstb, mem_wrstb}), 32'd0);
            if (resp_valid) begin
                n_resp++;
                chk("resp_busy", 32'(busy & ~req_ready), 32'd1);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/unexpected_resp: got rdata=%h err=%b required no response",
                             cur_name, resp_rdata, resp_err);
                end else begin
                    e = sbq.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("err", 32'(resp_err), 32'(e.err));
                    chk("latency", 32'(cyc - e0_cyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_ready();
        int budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s/ready_timeout: got req_ready=0 required 1", cur_name);
        end
    endtask

    task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] op, input logic we, input logic [31:0] exp_rd,
                          input logic exp_err, input int lat, input int nrd, input int nwr);
        int got;
        int budget;
        cur_name = name;
        wait_ready();
        n_rd = 0;
        n_wr = 0;
        rd_addrs.delete();
        cur_we = we;
        got = n_resp;
        sbq.push_back('{exp_rd, exp_err, lat});
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_memop = op;
        req_we    = we;
        @(posedge clk);
        #1;
        e0_cyc    = cyc;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
        req_memop = 3'b111;
        req_we    = 1'b1;
        budget = 0;
        while (n_resp == got && budget < 40) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (n_resp == got) begin
            checks++;
            errors++;
            $display("FAIL %s/resp_timeout: got no resp_valid required one", name);
            sbq.delete();
        end
        chk("n_rdstb", 32'(n_rd), 32'(nrd));
        chk("n_wrstb", 32'(n_wr), 32'(nwr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_memop = '0;
        req_we    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem", 32'(|{mem_addr, mem_datain, mem_memop, mem_we, mem_rdstb, mem_wrstb}), 32'd0);
        reset = 1'b0;

        // name, addr, wdata, memop, we, rdata, err, latency, rdstb, wrstb
        do_req("lw_10",   32'h10, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 1'b0, 2, 1, 0);
        do_req("lb_1",    32'h01, 32'h0, 3'b000, 1'b0, 32'h0000007F, 1'b0, 2, 1, 0);
        do_req("lb_2",    32'h02, 32'h0, 3'b000, 1'b0, 32'hFFFFFFFF, 1'b0, 2, 1, 0);
        do_req("lbu_3",   32'h03, 32'h0, 3'b100, 1'b0, 32'h00000080, 1'b0, 2, 1, 0);
        do_req("lhu_2",   32'h02, 32'h0, 3'b101, 1'b0, 32'h000080FF, 1'b0, 2, 1, 0);
        do_req("lh_2",    32'h02, 32'h0, 3'b001, 1'b0, 32'hFFFF80FF, 1'b0, 2, 1, 0);
        do_req("sw_10",   32'h10, 32'h11223344, 3'b010, 1'b1, 32'h0, 1'b0, 2, 1, 1);
        do_req("sh_12",   32'h12, 32'h0000BEEF, 3'b001, 1'b1, 32'h0, 1'b0, 2, 1, 1);
        do_req("lw_10b",  32'h10, 32'h0, 3'b010, 1'b0, 32'hBEEF3344, 1'b0, 2, 1, 0);

        do_req("lw_21", 32'h21, 32'h0, 3'b010, 1'b0, MIS ? 32'h55443322 : 32'h0, !MIS,
               MIS ? 11 : 0, MIS ? 4 : 0, 0);
`ifdef DMEM_LSU_MISALIGN_EN
        for (int i = 0; i < 4; i++)
            chk("mis_addr", (i < rd_addrs.size()) ? rd_addrs[i] : 32'hFFFF_FFFF, 32'h21 + 32'(i));
`endif
        do_req("lh_27",  32'h27, 32'h0, 3'b001, 1'b0, MIS ? 32'hFFFFCC88 : 32'h0, !MIS,
               MIS ? 5 : 0, MIS ? 2 : 0, 0);
        do_req("lhu_27", 32'h27, 32'h0, 3'b101, 1'b0, MIS ? 32'h0000CC88 : 32'h0, !MIS,
               MIS ? 5 : 0, MIS ? 2 : 0, 0);
        do_req("sh_31",  32'h31, 32'h1234A1B2, 3'b001, 1'b1, 32'h0, !MIS,
               MIS ? 5 : 0, MIS ? 2 : 0, MIS ? 2 : 0);
        do_req("lw_30",  32'h30, 32'h0, 3'b010, 1'b0, MIS ? 32'h00A1B200 : 32'h0, 1'b0, 2, 1, 0);

        do_req("op_011",   32'h10, 32'h0, 3'b011, 1'b0, 32'h0, 1'b1, 0, 0, 0);
        do_req("op_110",   32'h10, 32'h0, 3'b110, 1'b0, 32'h0, 1'b1, 0, 0, 0);
        do_req("st_op100", 32'h10, 32'hFFFFFFFF, 3'b100, 1'b1, 32'h0, 1'b1, 0, 0, 0);

        // Abort a store while in SRD; no response may appear and memory must be untouched.
        cur_name = "rst_srd";
        wait_ready();
        cur_we    = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hCAFEF00D;
        req_memop = 3'b010;
        req_we    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("srd_rdstb", 32'(mem_rdstb), 32'd1);
        chk("srd_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ab_ready", 32'(req_ready), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_wrstb", 32'(mem_wrstb), 32'd0);
        chk("ab_valid", 32'(resp_valid), 32'd0);
        repeat (4) @(negedge clk);
        do_req("lw_after", 32'h10, 32'h0, 3'b010, 1'b0, 32'hBEEF3344, 1'b0, 2, 1, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
